// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter; result, done and ovf register BIN_W clocks after the accepting edge.
// No queueing: start is only sampled while idle, so a start during a conversion is dropped.
module bin2bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin,
    output logic [4*DIGITS-1:0] bcd,
    output logic                busy,
    output logic                done,
    output logic                ovf
);
    localparam int          BCD_W   = 4 * DIGITS;
    localparam int          CNT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [31:0] MAX_VAL = 32'(10**DIGITS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q;
    logic [BIN_W-1:0]   shift_q;
    logic [BIN_W-1:0]   shift_d;
    logic [BCD_W-1:0]   scratch_q;
    logic [BCD_W-1:0]   scratch_d;
    logic [BCD_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_pend_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               busy_q;
    logic               done_q;
    logic               ovf_q;
    logic               bin_ovf;

    assign bin_ovf = 32'(bin) > MAX_VAL;

    // Per-digit add-3 with no inter-digit carry, then one-bit left shift of {scratch, shift}.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        {scratch_d, shift_d} = {adj, shift_q} << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q    <= bin;
                        scratch_q  <= '0;
                        cnt_q      <= '0;
                        ovf_pend_q <= bin_ovf;
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_q <= scratch_d;
                    shift_q   <= shift_d;
                    cnt_q     <= cnt_q + CNT_W'(1);
                    // The display word only ever sees a finished result, never partial scratch.
                    if (cnt_q == CNT_W'(BIN_W - 1)) begin
                        bcd_q   <= ovf_pend_q ? {DIGITS{4'h9}} : scratch_d;
                        ovf_q   <= ovf_pend_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bcd  = bcd_q;
    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed scenarios plus strided and random sweeps against a decimal-arithmetic model.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        busy;
    logic        done;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_bcd(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic ref_ovf(input int v);
        return v > 9999;
    endfunction

    // Drive start for one edge; returns #1 after the accepting edge.
    task automatic start_conv(input int v);
        bin   = 14'(v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Clocks from the accepting edge until done is seen; -1 if it never comes.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) begin
            start = 1'($urandom_range(0, 1));
            bin   = 14'($urandom);
            @(posedge clk); #1;
        end
        checks++; if (bcd !== 16'h0000) begin failures++; $display("FAIL reset_bcd: got %h want 0000", bcd); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero;
        int busy_n;
        int lat;
        start_conv(0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL zero_busy_e0: got %b want 1", busy); end
        busy_n = 1;
        lat    = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (busy) busy_n++;
            if (done) begin lat = k; break; end
        end
        checks++; if (lat !== 14) begin failures++; $display("FAIL zero_latency: got %0d want 14", lat); end
        checks++; if (busy_n !== 14) begin failures++; $display("FAIL zero_busy_cycles: got %0d want 14", busy_n); end
        checks++; if (bcd !== 16'h0000 || ovf !== 1'b0) begin failures++; $display("FAIL zero_result: got %h/%b want 0000/0", bcd, ovf); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_back_to_back;
        int vals[3] = '{255, 9999, 1000};
        int idx  = 0;
        int last = 0;
        bin   = 14'(vals[0]);
        start = 1'b1;
        for (int cyc = 1; cyc <= 80 && idx < 3; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                checks++;
                if (bcd !== ref_bcd(vals[idx]) || ovf !== ref_ovf(vals[idx])) begin
                    failures++; $display("FAIL b2b_result[%0d]: got %h/%b want %h/%b", idx, bcd, ovf, ref_bcd(vals[idx]), ref_ovf(vals[idx]));
                end
                checks++;
                if (cyc - last !== (idx == 0 ? 15 : 15)) begin
                    failures++; $display("FAIL b2b_spacing[%0d]: got %0d want 15", idx, cyc - last);
                end
                last = cyc;
                idx++;
                if (idx < 3) bin = 14'(vals[idx]);
                else start = 1'b0;
            end
        end
        start = 1'b0;
        checks++; if (idx !== 3) begin failures++; $display("FAIL b2b_count: got %0d want 3", idx); end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow;
        int vals[3] = '{10000, 16383, 42};
        int lat;
        foreach (vals[i]) begin
            start_conv(vals[i]);
            wait_done(lat);
            checks++; if (lat !== 14) begin failures++; $display("FAIL ovf_latency[%0d]: got %0d want 14", i, lat); end
            checks++;
            if (bcd !== ref_bcd(vals[i]) || ovf !== ref_ovf(vals[i])) begin
                failures++; $display("FAIL ovf_result[%0d]: got %h/%b want %h/%b", i, bcd, ovf, ref_bcd(vals[i]), ref_ovf(vals[i]));
            end
        end
    endtask

    task automatic test_start_while_busy;
        int cyc;
        int extra;
        start_conv(1234);
        repeat (4) begin @(posedge clk); #1; end
        bin   = 14'd77;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 5;
        for (int k = 0; k < 40; k++) begin
            bin = 14'($urandom);
            @(posedge clk); #1;
            cyc++;
            if (done) break;
        end
        checks++; if (cyc !== 14) begin failures++; $display("FAIL busy_start_latency: got %0d want 14", cyc); end
        checks++; if (bcd !== 16'h1234) begin failures++; $display("FAIL busy_start_bcd: got %h want 1234", bcd); end
        extra = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL busy_start_queued: got %0d active cycles want 0", extra); end
    endtask

    task automatic test_reset_mid;
        int lat;
        int seen;
        start_conv(500);
        wait_done(lat);
        checks++; if (bcd !== 16'h0500) begin failures++; $display("FAIL rstmid_pre: got %h want 0500", bcd); end
        start_conv(321);
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (bcd !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            failures++; $display("FAIL rstmid_state: got bcd=%h busy=%b done=%b ovf=%b want 0000/0/0/0", bcd, busy, done, ovf);
        end
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rstmid_no_done: got %0d want 0", seen); end
        start_conv(321);
        wait_done(lat);
        checks++; if (lat !== 14) begin failures++; $display("FAIL rstmid_latency: got %0d want 14", lat); end
        checks++; if (bcd !== 16'h0321) begin failures++; $display("FAIL rstmid_bcd: got %h want 0321", bcd); end
    endtask

    task automatic test_sweep;
        int lat;
        int ovf_seen = 0;
        for (int v = 0; v <= 9999; v = (v + 7 > 9999 && v != 9999) ? 9999 : v + 7) begin
            start_conv(v);
            wait_done(lat);
            checks++;
            if (lat !== 14 || bcd !== ref_bcd(v)) begin
                failures++; $display("FAIL sweep[%0d]: got %h lat=%0d want %h lat=14", v, bcd, lat, ref_bcd(v));
            end
            if (ovf) ovf_seen++;
            if (v == 9999) break;
        end
        checks++; if (ovf_seen !== 0) begin failures++; $display("FAIL sweep_ovf: got %0d flagged want 0", ovf_seen); end
    endtask

    task automatic test_random;
        int lat;
        int v;
        for (int n = 0; n < 200; n++) begin
            v = (n % 4 == 0) ? $urandom_range(9990, 10010) : $urandom_range(0, 16383);
            start_conv(v);
            wait_done(lat);
            checks++;
            if (lat !== 14 || bcd !== ref_bcd(v) || ovf !== ref_ovf(v)) begin
                failures++; $display("FAIL random[%0d]: got %h/%b lat=%0d want %h/%b lat=14", v, bcd, ovf, lat, ref_bcd(v), ref_ovf(v));
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        test_reset;
        test_zero;
        test_back_to_back;
        test_overflow;
        test_start_while_busy;
        test_reset_mid;
        test_sweep;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential double-dabble converter between the ALU result path and the 4-digit seven-segment controller. Replaces the combinational binary-to-BCD stage with an iterative shift-add-3 engine. Accepts a binary value on a start pulse and produces a held, registered 4-digit packed BCD word with a one-cycle done pulse. Values above 9999 saturate to 9999 and raise an overflow flag.

## Interface
- BIN_W, 14: binary input width; conversion takes BIN_W shift iterations.
- DIGITS, 4: BCD digits produced; output width is 4*DIGITS.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bin  input  BIN_W  unsigned binary value; sampled on the accepting edge only.
- bcd  output  4*DIGITS  packed BCD; digit 0 (ones) in [3:0], thousands in [15:12]; registered, held between conversions.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd/ovf valid and updated.
- ovf  output  1  the last completed conversion had bin > 10^DIGITS − 1 (9999); registered with bcd.

## Operation
- States: IDLE, SHIFT. Reset state is IDLE.
- IDLE, start=1: latch bin into the shift register. Clear the BCD scratch register (4*DIGITS bits). Clear iteration counter. Capture ovf_pending = (bin > 9999). Go to SHIFT with busy=1.
- IDLE, start=0: no change; bcd/ovf hold.
- SHIFT, each cycle:
  - Every scratch digit ≥ 5 gets +3, using 4-bit add per digit, no carry between digits.
  - Then {scratch, shift} shifts left by one.
  - Counter increments.
- SHIFT, on the BIN_W-th shift (counter == BIN_W−1):
  - Load bcd with the post-shift scratch value, or with all-9s (16'h9999) if ovf_pending.
  - Load ovf = ovf_pending.
  - done=1 next cycle; busy=0; go to IDLE.
- start while busy: ignored; not queued.
- bin changes after acceptance: no effect on the running conversion.
- Counter width is ceil(log2(BIN_W)); it never wraps within a conversion.
- Scratch is never wider than 4*DIGITS. Overflowed conversions still run all iterations. Upper-bit loss is irrelevant because the result is replaced by saturation.
- Reset, including mid-conversion: state=IDLE, busy=0, done=0, bcd=0, ovf=0. The in-flight conversion is discarded.

## Timing
- Accepting edge E0 (IDLE, start=1): busy=1 from E0.
- Shifts occur on edges E1..E14 (for BIN_W=14).
- At E14: bcd and ovf update, done=1, busy=0. done drops at E15.
- Latency: 14 clocks from the accepting edge to valid bcd/done.
- The done cycle is an IDLE cycle, so start may be asserted during it and is accepted at E15. Back-to-back throughput is one result per 15 clocks.
- start held continuously high: a new conversion starts every 15 clocks.
- bcd changes only on a completing edge or on reset. It never shows partial scratch values, so the display stays glitch-free.
- No combinational path from any input to any output.

## Test plan
- Reset, then start with bin=0 → done at E14, bcd=16'h0000, ovf=0; busy high for exactly 14 cycles.
- bin=255 → bcd=16'h0255. Then bin=9999 → bcd=16'h9999, ovf=0. Then bin=1000 → 16'h1000. All three issued back-to-back with start held high; done pulses spaced 15 clocks apart.
- bin=10000 → bcd=16'h9999, ovf=1. bin=16383 → 16'h9999, ovf=1. Next bin=42 → bcd=16'h0042, ovf clears to 0.
- Start with bin=1234, then pulse start with bin=77 at E5 and change bin mid-run → single done at E14 with bcd=16'h1234. The second start is not serviced.
- Convert 500 (bcd=16'h0500), then start bin=321 and assert rst at E7 → bcd=0, busy=0, and no done. A fresh start with bin=321 then gives 16'h0321 after 14 clocks.
- Sweep bin 0..9999 and compare each result against a reference model → all match, ovf=0 throughout.
